// File: rtl/lsu_mem_req.sv
// ============================================================================
// lsu_mem_req : load/store requester driving the 64-bit data-memory port.
// Optional misaligned-access check: LSU_MISALIGN_CHK_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_mem_req #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [63:0]       mem_wdata_q;
    logic [7:0]        mem_wmask_q;
    logic [63:0]       rdata_q;

    logic              accept;
    logic              misalign;
    logic [2:0]        req_off;
    logic [2:0]        align_m;
    logic [2:0]        eff_off;
    logic [7:0]        base_mask;
    logic [63:0]       rd_shift;
    logic [63:0]       rd_ext;

    assign accept  = req_valid && req_ready;
    assign req_off = req_addr[2:0];

    always_comb begin
        align_m   = 3'b111;
        base_mask = 8'hFF;
        case (req_size)
            2'd0:    begin align_m = 3'b000; base_mask = 8'h01; end
            2'd1:    begin align_m = 3'b001; base_mask = 8'h03; end
            2'd2:    begin align_m = 3'b011; base_mask = 8'h0F; end
            default: begin align_m = 3'b111; base_mask = 8'hFF; end
        endcase
    end

    // Aligned requests are unaffected; misaligned ones are rounded down
    // (only reachable for the memory path when the check is disabled).
    assign eff_off = req_off & ~align_m;

`ifdef LSU_MISALIGN_CHK_EN
    logic resp_err_q;

    assign misalign = |(req_off & align_m);
    assign resp_err = resp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_q <= 1'b0;
        end else if (accept) begin
            resp_err_q <= misalign;
        end
    end
`else
    assign misalign = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)     state_d = misalign ? S_RESP : S_REQ;
            S_REQ:  if (mem_gnt)    state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT: if (mem_rvalid) state_d = S_RESP;
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rst_n && (state_q == S_IDLE);
        mem_ce     = (state_q == S_REQ);
        mem_we     = (state_q == S_REQ) && we_q;
        resp_valid = (state_q == S_RESP);
    end

    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rd_ext = {{56{~uns_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    rd_ext = {{48{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    rd_ext = {{32{~uns_q & rd_shift[31]}}, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Memory-side fields are built once at acceptance so they stay frozen in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= 3'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q     <= '0;
        end else if (accept) begin
            we_q        <= req_we;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            off_q       <= eff_off;
            mem_addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
            mem_wdata_q <= req_wdata << {eff_off, 3'b000};
            mem_wmask_q <= base_mask << eff_off;
            rdata_q     <= '0;
        end else if ((state_q == S_WAIT) && mem_rvalid) begin
            rdata_q     <= rd_ext;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign resp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_req.sv
// ============================================================================
// tb_lsu_mem_req : directed self-checking bench for lsu_mem_req.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_req;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    lsu_mem_req #(.ADDR_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ce       (mem_ce),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_gnt    = 0;

    logic        chk_en;
    logic        exp_ready, exp_ce, exp_resp, exp_we, exp_err;
    logic [63:0] exp_addr, exp_wdata, exp_rdata;
    logic [7:0]  exp_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic int eoff_of(input logic [63:0] addr, input logic [1:0] size);
        int off;
        off = int'(addr[2:0]);
        return off - (off % nbytes_of(size));
    endfunction

    function automatic logic mis_of(input logic [63:0] addr, input logic [1:0] size);
`ifdef LSU_MISALIGN_CHK_EN
        return (int'(addr[2:0]) % nbytes_of(size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_mask(input logic [63:0] addr, input logic [1:0] size);
        logic [7:0] m;
        int e;
        m = '0;
        e = eoff_of(addr, size);
        for (int i = 0; i < 8; i++)
            if (i >= e && i < e + nbytes_of(size)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] addr, input logic [1:0] size,
                                                input logic [63:0] wd);
        logic [63:0] r;
        int e;
        r = '0;
        e = eoff_of(addr, size);
        for (int i = 0; i < 8; i++)
            if (i >= e) r[8*i +: 8] = wd[8*(i-e) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_rdata(input logic [63:0] addr, input logic [1:0] size,
                                                input logic uns, input logic [63:0] line);
        logic [63:0] r;
        int e, n;
        r = '0;
        e = eoff_of(addr, size);
        n = nbytes_of(size);
        for (int i = 0; i < n; i++) r[8*i +: 8] = line[8*(e+i) +: 8];
        if (!uns && n < 8 && r[8*n-1])
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("mem_ce", 64'(mem_ce), 64'(exp_ce));
            check("resp_valid", 64'(resp_valid), 64'(exp_resp));
            if (exp_ce) begin
                check("mem_we", 64'(mem_we), 64'(exp_we));
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wmask", 64'(mem_wmask), 64'(exp_mask));
                check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_resp) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", 64'(resp_err), 64'(exp_err));
            end
            if (mem_ce && mem_gnt) n_gnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [63:0] addr, input logic we, input logic [1:0] size,
                          input logic uns, input logic [63:0] wdata, input logic [63:0] line,
                          input int gd, input int rd, input int rrd,
                          input logic lit_m_en, input logic [7:0] lit_m,
                          input logic lit_r_en, input logic [63:0] lit_r);
        logic mis;
        int   g0;
        mis = mis_of(addr, size);
        g0  = n_gnt;
        tick();
        req_valid    = 1'b1;
        req_addr     = addr;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        exp_addr     = {addr[63:3], 3'b000};
        exp_we       = we;
        exp_mask     = model_mask(addr, size);
        exp_wdata    = model_wdata(addr, size, wdata);
        exp_rdata    = (we || mis) ? 64'd0 : model_rdata(addr, size, uns, line);
        exp_err      = mis;
        tick();
        // scramble the request inputs to prove they were latched
        req_valid    = 1'b0;
        req_addr     = ~addr;
        req_we       = ~we;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_wdata    = ~wdata;
        exp_ready    = 1'b0;
        if (mis) begin
            exp_resp = 1'b1;
        end else begin
            exp_ce = 1'b1;
            if (lit_m_en) check("lit_wmask", 64'(mem_wmask), 64'(lit_m));
            repeat (gd) begin
                mem_rvalid = !we;
                mem_rdata  = ~line;
                tick();
            end
            mem_gnt = 1'b1;
            if (!we) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ~line;
            end
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            exp_ce     = 1'b0;
            if (!we) begin
                repeat (rd) tick();
                mem_rvalid = 1'b1;
                mem_rdata  = line;
                tick();
                mem_rvalid = 1'b0;
                mem_rdata  = {$urandom, $urandom};
            end
            exp_resp = 1'b1;
        end
        if (lit_r_en) check("lit_rdata", resp_rdata, lit_r);
        repeat (rrd) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        exp_resp   = 1'b0;
        exp_ready  = 1'b1;
        check("gnt_count", 64'(n_gnt - g0), mis ? 64'd0 : 64'd1);
    endtask

    initial begin
        chk_en       = 1'b0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        resp_ready   = 1'b0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        exp_ready    = 1'b1;
        exp_ce       = 1'b0;
        exp_resp     = 1'b0;
        exp_we       = 1'b0;
        exp_err      = 1'b0;
        exp_addr     = '0;
        exp_wdata    = '0;
        exp_rdata    = '0;
        exp_mask     = '0;

        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_mem_ce", 64'(mem_ce), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'd1);
        chk_en = 1'b1;

        // store byte, offset 5
        do_txn(64'h0000_0000_8000_0005, 1'b1, 2'd0, 1'b0, 64'hAB, 64'd0, 0, 0, 0,
               1'b1, 8'h20, 1'b1, 64'd0);
        // signed / unsigned half loads at offset 6
        do_txn(64'h0000_0000_1000_0006, 1'b0, 2'd1, 1'b0, 64'd0, 64'h8001_1234_5678_9ABC, 0, 0, 0,
               1'b1, 8'hC0, 1'b1, 64'hFFFF_FFFF_FFFF_8001);
        do_txn(64'h0000_0000_1000_0006, 1'b0, 2'd1, 1'b1, 64'd0, 64'h8001_1234_5678_9ABC, 0, 0, 0,
               1'b1, 8'hC0, 1'b1, 64'h0000_0000_0000_8001);
        // backpressure on every handshake
        do_txn(64'h0000_0000_1000_0004, 1'b0, 2'd2, 1'b0, 64'd0, 64'h8765_4321_0000_0000, 3, 2, 4,
               1'b1, 8'hF0, 1'b1, 64'hFFFF_FFFF_8765_4321);
        do_txn(64'h0000_0000_1000_0002, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 64'd0, 3, 0, 4,
               1'b1, 8'h0C, 1'b1, 64'd0);
        // doubleword store/load
        do_txn(64'h0000_0000_2000_0010, 1'b1, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0, 1,
               1'b1, 8'hFF, 1'b1, 64'd0);
        do_txn(64'h0000_0000_2000_0010, 1'b0, 2'd3, 1'b0, 64'd0, 64'hFEDC_BA98_7654_3210, 1, 1, 0,
               1'b1, 8'hFF, 1'b1, 64'hFEDC_BA98_7654_3210);
        // top byte lane, signed and unsigned
        do_txn(64'h0000_0000_3000_0007, 1'b0, 2'd0, 1'b0, 64'd0, 64'h80FF_FFFF_FFFF_FFFF, 0, 0, 0,
               1'b1, 8'h80, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        do_txn(64'h0000_0000_3000_0007, 1'b0, 2'd0, 1'b1, 64'd0, 64'h80FF_FFFF_FFFF_FFFF, 0, 0, 0,
               1'b1, 8'h80, 1'b1, 64'h0000_0000_0000_0080);
        // misaligned word at offset 2
`ifdef LSU_MISALIGN_CHK_EN
        do_txn(64'h0000_0000_4000_0002, 1'b1, 2'd2, 1'b0, 64'h1122_3344, 64'd0, 0, 0, 0,
               1'b0, 8'h00, 1'b1, 64'd0);
        do_txn(64'h0000_0000_4000_0002, 1'b0, 2'd2, 1'b0, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 0,
               1'b0, 8'h00, 1'b1, 64'd0);
`else
        do_txn(64'h0000_0000_4000_0002, 1'b1, 2'd2, 1'b0, 64'h1122_3344, 64'd0, 0, 0, 0,
               1'b1, 8'h0F, 1'b1, 64'd0);
        do_txn(64'h0000_0000_4000_0002, 1'b0, 2'd2, 1'b0, 64'd0, 64'h1122_3344_9566_7788, 0, 0, 0,
               1'b1, 8'h0F, 1'b1, 64'hFFFF_FFFF_9566_7788);
`endif

        // reset asserted while waiting for read data
        tick();
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_5000_0008;
        req_we    = 1'b0;
        req_size  = 2'd3;
        exp_addr  = 64'h0000_0000_5000_0008;
        exp_we    = 1'b0;
        exp_mask  = 8'hFF;
        exp_wdata = '0;
        req_wdata = '0;
        tick();
        req_valid = 1'b0;
        exp_ready = 1'b0;
        exp_ce    = 1'b1;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        exp_ce    = 1'b0;
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd0);
        check("arst_mem_ce", 64'(mem_ce), 64'd0);
        check("arst_mem_we", 64'(mem_we), 64'd0);
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_resp_err", 64'(resp_err), 64'd0);
        check("arst_mem_addr", mem_addr, 64'd0);
        check("arst_mem_wdata", mem_wdata, 64'd0);
        check("arst_mem_wmask", 64'(mem_wmask), 64'd0);
        check("arst_resp_rdata", resp_rdata, 64'd0);
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        exp_ready  = 1'b1;
        chk_en     = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        tick();
        tick();

        // normal operation after the mid-transaction reset
        do_txn(64'h0000_0000_6000_0000, 1'b0, 2'd2, 1'b1, 64'd0, 64'h0000_0000_F00D_CAFE, 0, 0, 0,
               1'b1, 8'h0F, 1'b1, 64'h0000_0000_F00D_CAFE);
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
